// File: rtl/sched_pkg.sv
// Shared scheduler types and default sizing for the select/issue stage and its age matrix.
package sched_pkg;

    localparam int RS_ENTRIES = 8;
    localparam int NUM_FUS    = 2;

    typedef logic [$clog2(RS_ENTRIES)-1:0] rs_idx_t;

    typedef struct packed {
        logic    valid;
        rs_idx_t entry;
    } bcast_t;

endpackage

// File: rtl/age_matrix.sv
// Dispatch-order age matrix: older_q[i][j]=1 means entry i is older than entry j.
// Emits the requesting entries that no other requesting entry is older than.
module age_matrix
    import sched_pkg::*;
#(
    parameter int N     = RS_ENTRIES,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             disp_valid,
    input  logic [IDX_W-1:0] disp_entry,
    input  logic [N-1:0]     reqs,
    output logic [N-1:0]     oldest
);

    logic [N-1:0][N-1:0] older_q;
    logic [N-1:0][N-1:0] older_d;
    logic [N-1:0]        blocked;

    // NOTE: every variable driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        older_d = older_q;
        if (disp_valid) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    if (IDX_W'(i) == disp_entry) begin
                        older_d[i][j] = 1'b0;
                    end else if (IDX_W'(j) == disp_entry) begin
                        older_d[i][j] = 1'b1;
                    end
                end
            end
        end
    end

    // Selection reads the pre-update matrix, so a same-cycle dispatch never affects it.
    always_comb begin
        blocked = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                blocked[i] = blocked[i] | (reqs[j] & older_q[j][i]);
            end
        end
        oldest = reqs & ~blocked;
    end

    // NOTE: the matrix is reset as a whole; with stale bits a never-dispatched entry could look younger than a live one.
    always_ff @(posedge clk) begin
        if (rst) begin
            older_q <= '0;
        end else begin
            older_q <= older_d;
        end
    end

endmodule

// File: rtl/select_issue.sv
// Per-FU select/issue stage: oldest-first pick, issue register with valid/ready, and a
// FU_LATENCY-deep completion broadcast. Define SELECT_AGE_EN for age ordering; otherwise lowest index wins.
module select_issue
    import sched_pkg::*;
#(
    parameter int RS_ENTRIES = sched_pkg::RS_ENTRIES,
    parameter int NUM_FUS    = sched_pkg::NUM_FUS,
    parameter int FU_ID      = 0,
    parameter int FU_LATENCY = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [RS_ENTRIES-1:0]              reqs,
    input  logic                               disp_valid,
    input  logic [$clog2(RS_ENTRIES)-1:0]      disp_entry,
    output logic [$clog2(RS_ENTRIES)-1:0]      grant,
    output logic                               grant_valid,
    output logic                               issue_valid,
    output logic [$clog2(RS_ENTRIES)-1:0]      issue_entry,
    input  logic                               issue_ready,
    output logic [RS_ENTRIES*NUM_FUS-1:0]      ready_mask
);

    localparam int IDX_W  = $clog2(RS_ENTRIES);
    localparam int MASK_W = RS_ENTRIES * NUM_FUS;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] entry;
    } stage_t;

    logic [RS_ENTRIES-1:0] cand;
    logic                  issue_valid_q, issue_valid_d;
    logic [IDX_W-1:0]      issue_entry_q, issue_entry_d;
    logic                  handshake;
    stage_t [FU_LATENCY-1:0] stage_q;
    stage_t [FU_LATENCY-1:0] stage_d;
    stage_t                last_stage;

`ifdef SELECT_AGE_EN
    age_matrix #(
        .N     (RS_ENTRIES),
        .IDX_W (IDX_W)
    ) u_age_matrix (
        .clk        (clk),
        .rst        (rst),
        .disp_valid (disp_valid),
        .disp_entry (disp_entry),
        .reqs       (reqs),
        .oldest     (cand)
    );
`else
    logic unused_disp;
    assign unused_disp = ^{disp_valid, disp_entry};
    assign cand        = reqs;
`endif

    // Descending scan so the lowest surviving index is the last one written.
    always_comb begin
        grant = '0;
        for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
            if (cand[i]) begin
                grant = IDX_W'(i);
            end
        end
    end

    // A stalled, full issue register withholds the grant so wakeup never marks an entry it cannot hold.
    assign grant_valid = (|reqs) && (!issue_valid_q || issue_ready);
    assign handshake   = issue_valid_q && issue_ready;

    always_comb begin
        issue_valid_d = issue_valid_q;
        issue_entry_d = issue_entry_q;
        if (grant_valid) begin
            issue_valid_d = 1'b1;
            issue_entry_d = grant;
        end else if (issue_ready) begin
            issue_valid_d = 1'b0;
        end
    end

    always_comb begin
        stage_d          = stage_q;
        stage_d[0].valid = handshake;
        stage_d[0].entry = issue_entry_q;
        for (int k = 1; k < FU_LATENCY; k++) begin
            stage_d[k] = stage_q[k-1];
        end
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_valid_q <= 1'b0;
            issue_entry_q <= '0;
            stage_q       <= '0;
        end else begin
            issue_valid_q <= issue_valid_d;
            issue_entry_q <= issue_entry_d;
            stage_q       <= stage_d;
        end
    end

    assign last_stage  = stage_q[FU_LATENCY-1];
    assign ready_mask  = last_stage.valid
                       ? (MASK_W'(1) << (FU_ID * RS_ENTRIES + int'(last_stage.entry)))
                       : '0;
    assign issue_valid = issue_valid_q;
    assign issue_entry = issue_entry_q;

endmodule

// File: tb/tb_select_issue.sv
// Directed bench for select_issue (FU_ID=1, FU_LATENCY=3, 8 entries, 2 FUs); age checks follow SELECT_AGE_EN.
module tb_select_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  reqs;
    logic        disp_valid;
    logic [2:0]  disp_entry;
    logic [2:0]  grant;
    logic        grant_valid;
    logic        issue_valid;
    logic [2:0]  issue_entry;
    logic        issue_ready;
    logic [15:0] ready_mask;

    int checks = 0;
    int errors = 0;

    select_issue #(
        .RS_ENTRIES (8),
        .NUM_FUS    (2),
        .FU_ID      (1),
        .FU_LATENCY (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .reqs        (reqs),
        .disp_valid  (disp_valid),
        .disp_entry  (disp_entry),
        .grant       (grant),
        .grant_valid (grant_valid),
        .issue_valid (issue_valid),
        .issue_entry (issue_entry),
        .issue_ready (issue_ready),
        .ready_mask  (ready_mask)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge, then leave 1ns so inputs change away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        reqs        = '0;
        disp_valid  = 1'b0;
        disp_entry  = '0;
        issue_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0] exp_age_grant;

        // Reset with all requests pending
        rst         = 1'b1;
        reqs        = 8'hFF;
        disp_valid  = 1'b0;
        disp_entry  = '0;
        issue_ready = 1'b1;
        tick();
        settle();
        check("rst_grant",       32'(grant),       32'd0);
        check("rst_grant_valid", 32'(grant_valid), 32'd1);
        check("rst_issue_valid", 32'(issue_valid), 32'd0);
        check("rst_ready_mask",  32'(ready_mask),  32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_issue_valid", 32'(issue_valid), 32'd1);
        check("post_rst_issue_entry", 32'(issue_entry), 32'd0);

        // Age order: dispatch 5, 2, 7
        do_reset();
        disp_valid = 1'b1;
        disp_entry = 3'd5;
        tick();
        disp_entry = 3'd2;
        tick();
        disp_entry = 3'd7;
        tick();
        disp_valid = 1'b0;
`ifdef SELECT_AGE_EN
        exp_age_grant = 3'd5;
`else
        exp_age_grant = 3'd2;
`endif
        reqs = 8'hA4;
        settle();
        check("age_grant_a4",  32'(grant),       32'(exp_age_grant));
        check("age_gv_a4",     32'(grant_valid), 32'd1);
        reqs = 8'h84;
        settle();
        check("age_grant_84",  32'(grant),       32'd2);
        reqs = 8'h80;
        settle();
        check("age_grant_80",  32'(grant),       32'd7);
        reqs = 8'h00;
        settle();
        check("no_req_grant",  32'(grant),       32'd0);
        check("no_req_gv",     32'(grant_valid), 32'd0);

        // Backpressure: entry 3 held while the FU stalls
        do_reset();
        issue_ready = 1'b0;
        reqs        = 8'h08;
        tick();
        check("bp_load_valid", 32'(issue_valid), 32'd1);
        check("bp_load_entry", 32'(issue_entry), 32'd3);
        reqs = 8'h10;
        for (int c = 0; c < 3; c++) begin
            settle();
            check($sformatf("bp_gv_%0d", c), 32'(grant_valid), 32'd0);
            tick();
            check($sformatf("bp_entry_%0d", c), 32'(issue_entry), 32'd3);
            check($sformatf("bp_valid_%0d", c), 32'(issue_valid), 32'd1);
        end
        issue_ready = 1'b1;
        settle();
        check("bp_release_gv",    32'(grant_valid), 32'd1);
        check("bp_release_grant", 32'(grant),       32'd4);
        tick();
        check("bp_next_entry",    32'(issue_entry), 32'd4);

        // Broadcast: entry 3 handshook one cycle earlier than entry 4 (this cycle, T)
        reqs = 8'h00;
        settle();
        check("bc_t0", 32'(ready_mask), 32'h0000);
        tick();
        check("bc_t1", 32'(ready_mask), 32'h0000);
        tick();
        check("bc_t2", 32'(ready_mask), 32'h0800);
        tick();
        check("bc_t3", 32'(ready_mask), 32'h1000);
        tick();
        check("bc_t4", 32'(ready_mask), 32'h0000);

        // Streaming entries 1, 3, 6
        do_reset();
        reqs = 8'h02;
        tick();
        check("st_entry_1", 32'(issue_entry), 32'd1);
        reqs = 8'h08;
        tick();
        check("st_entry_3", 32'(issue_entry), 32'd3);
        reqs = 8'h40;
        tick();
        check("st_entry_6", 32'(issue_entry), 32'd6);
        reqs = 8'h00;
        tick();
        check("st_mask_1", 32'(ready_mask), 32'h0200);
        tick();
        check("st_mask_3", 32'(ready_mask), 32'h0800);
        tick();
        check("st_mask_6", 32'(ready_mask), 32'h4000);
        tick();
        check("st_mask_end", 32'(ready_mask), 32'h0000);

        // Reset one cycle after the handshake of entry 5
        do_reset();
        reqs = 8'h20;
        tick();
        check("mf_entry", 32'(issue_entry), 32'd5);
        reqs = 8'h00;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mf_valid", 32'(issue_valid), 32'd0);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("mf_mask_%0d", c), 32'(ready_mask), 32'h0000);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/select_issue.md
# select_issue

Per-FU select and issue stage, directly downstream of the scheduler wakeup block. Each cycle it picks one ready reservation-station entry from the wakeup request vector, oldest-first, and returns the grant to wakeup. It holds the granted entry in an issue register with a valid/ready handshake to the functional unit. After the FU latency it broadcasts that entry's completion bit in the ready mask back to wakeup.

## Interface
- RS_ENTRIES, default sched_pkg::RS_ENTRIES (8): reservation-station depth
- NUM_FUS, default sched_pkg::NUM_FUS (2): FU pipes; sets the ready-mask width
- FU_ID, default 0: this pipe's index, 0..NUM_FUS-1
- FU_LATENCY, default 1: cycles from issue handshake to dependent wakeup, 1..8

Ports:
- clk  in  1  clock. One clock domain.
- rst  in  1  reset. Synchronous, active-high.
- reqs  in  RS_ENTRIES  request vector from wakeup
- disp_valid  in  1  dispatch accepted this cycle; already qualified by !full
- disp_entry  in  $clog2(RS_ENTRIES)  entry being written by dispatch
- grant  out  $clog2(RS_ENTRIES)  selected entry, to wakeup
- grant_valid  out  1  grant is valid
- issue_valid  out  1  issue register holds an entry
- issue_entry  out  $clog2(RS_ENTRIES)  entry in the issue register
- issue_ready  in  1  FU accepts this cycle
- ready_mask  out  RS_ENTRIES*NUM_FUS  completion broadcast, to wakeup

## Operation
- Candidates: reqs filtered by age.
  - Bit i survives if no j with reqs[j] && older[j][i].
  - grant = lowest-index surviving bit.
  - grant = 0 when no request.
- grant_valid = |reqs && (!issue_valid || issue_ready).
  - A full issue register that is stalled blocks the grant, so no entry is marked granted and lost.
- Age matrix: older[i][j]=1 means entry i is older than entry j.
  - On disp_valid, row disp_entry is cleared and column disp_entry is set for every i != disp_entry.
  - The diagonal is always 0.
- Issue register:
  - On grant_valid it loads grant and sets issue_valid.
  - Otherwise, if issue_ready, it clears issue_valid.
- Broadcast pipeline: FU_LATENCY stages, each holding {valid, entry}.
  - Stage 0 is loaded by the issue handshake (issue_valid && issue_ready).
- ready_mask: one-hot from the last stage.
  - Bit index is FU_ID*RS_ENTRIES + entry.
  - High for exactly one cycle per handshake.
  - All other bits are 0.
- Simultaneous dispatch and grant: a dispatched entry cannot appear in reqs in its dispatch cycle. The age update and selection are independent; selection uses the pre-update matrix.
- Re-dispatch to a recycled entry makes it the youngest. No retire input is needed.

## Timing
- Reset values:
  - older all 0, so selection degenerates to lowest index.
  - issue_valid=0, issue_entry=0.
  - All pipeline valids 0, ready_mask=0.
  - grant and grant_valid follow reqs combinationally.
- reqs to grant/grant_valid: combinational, same cycle.
- Grant in cycle T gives issue_valid from cycle T+1.
- Issue handshake in cycle T gives ready_mask high in cycle T+FU_LATENCY.
  - A dependent in wakeup requests at T+FU_LATENCY+1.
- Back-to-back issue: one entry per cycle while issue_ready stays high.
- issue_entry is stable while issue_valid && !issue_ready.
- rst mid-operation:
  - All in-flight broadcasts are dropped.
  - ready_mask=0 the next cycle.
  - Age history is lost.

## Configuration
- SELECT_AGE_EN defined: age-matrix oldest-first selection as above.
- SELECT_AGE_EN undefined:
  - No age matrix is instantiated.
  - grant = lowest-index set bit of reqs.
  - disp_valid and disp_entry are ignored.
  - All other timing is identical.

## Structure
- sched_pkg holds:
  - RS_ENTRIES, NUM_FUS
  - typedef rs_idx_t (logic [$clog2(RS_ENTRIES)-1:0])
  - struct bcast_t {valid, rs_idx_t entry}
- Sub-module age_matrix:
  - Inputs: clk, rst, disp_valid, disp_entry, reqs.
  - Output: oldest-candidate vector.
  - Instantiated only under SELECT_AGE_EN.
- The priority encoder, issue register and broadcast pipeline stay in select_issue.

## Test plan
- Reset:
  - Assert rst with reqs=8'hFF: grant=0, grant_valid=1, issue_valid=0, ready_mask=0.
  - Next cycle after deassert, issue_valid=1, issue_entry=0.
- Age order (SELECT_AGE_EN): dispatch entries 5, 2, 7 in consecutive cycles, then reqs=8'hA4 gives grant=5. Drop bit 5 and grant=2.
- Backpressure: issue_valid=1 with issue_ready=0 for 3 cycles and reqs=8'h10. grant_valid=0 throughout and issue_entry is unchanged.
- Broadcast, FU_LATENCY=3, FU_ID=1, RS_ENTRIES=8: handshake of entry 4 at T. ready_mask bit 12 is high only in cycle T+3.
- Streaming: issue_ready=1 with single requests of entry 1, 3, 6 in successive cycles. ready_mask shows bits for 1, 3, 6 in consecutive cycles, none lost.
- Reset mid-flight: rst one cycle after a handshake with FU_LATENCY=3. ready_mask stays 0.
